// File: rtl/fpu_ss_pkg.sv
// Shared types and default sizes for the FPU subsystem writeback path.
package fpu_ss_pkg;

  localparam int unsigned NumWords  = 32;
  localparam int unsigned AddrWidth = 5;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned NumRead   = 3;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
  } wb_req_t;

  // Round-robin pointer: which requester wins the next contested cycle.
  typedef enum logic {
    WB_FPU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/fpu_ss_scoreboard.sv
// Per-register pending-write bits with RAW/WAW hazard detection for issue.
module fpu_ss_scoreboard
  import fpu_ss_pkg::*;
#(
  parameter int unsigned NumWords  = fpu_ss_pkg::NumWords,
  parameter int unsigned AddrWidth = fpu_ss_pkg::AddrWidth,
  parameter int unsigned NumRead   = fpu_ss_pkg::NumRead
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_set,
  input  logic [AddrWidth-1:0]              i_set_addr,
  input  logic                              i_clr,
  input  logic [AddrWidth-1:0]              i_clr_addr,
  input  logic [NumRead-1:0][AddrWidth-1:0] i_rs_addr,
  input  logic [NumRead-1:0]                i_rs_use,
  output logic                              o_hazard,
  output logic [NumWords-1:0]               o_busy
);

  logic [NumWords-1:0] r_busy;
  logic [NumWords-1:0] w_set_dec;
  logic [NumWords-1:0] w_clr_dec;
  logic                w_raw;
  logic                w_waw;

  assign w_set_dec = i_set ? (NumWords'(1) << i_set_addr) : '0;
  assign w_clr_dec = i_clr ? (NumWords'(1) << i_clr_addr) : '0;

  // Set is applied after clear so a newly issued producer survives a
  // writeback to the same register on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_busy <= '0;
    else          r_busy <= (r_busy & ~w_clr_dec) | w_set_dec;
  end

  always_comb begin
    w_raw = 1'b0;
    for (int i = 0; i < int'(NumRead); i++) begin
      if (i_rs_use[i] && r_busy[i_rs_addr[i]]) w_raw = 1'b1;
    end
  end

  assign w_waw    = i_set & r_busy[i_set_addr];
  assign o_hazard = w_raw | w_waw;
  assign o_busy   = r_busy;

endmodule

// File: rtl/fpu_ss_wb_ctrl.sv
// Single-port regfile writeback: round-robin FPU/load arbitration, one-cycle
// output register, and the pending-write scoreboard used by issue.
module fpu_ss_wb_ctrl
  import fpu_ss_pkg::*;
#(
  parameter int unsigned NumWords  = fpu_ss_pkg::NumWords,
  parameter int unsigned AddrWidth = fpu_ss_pkg::AddrWidth,
  parameter int unsigned DataWidth = fpu_ss_pkg::DataWidth,
  parameter int unsigned NumRead   = fpu_ss_pkg::NumRead
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              fpu_valid_i,
  output logic                              fpu_ready_o,
  input  logic [AddrWidth-1:0]              fpu_waddr_i,
  input  logic [DataWidth-1:0]              fpu_wdata_i,
  input  logic                              mem_valid_i,
  output logic                              mem_ready_o,
  input  logic [AddrWidth-1:0]              mem_waddr_i,
  input  logic [DataWidth-1:0]              mem_wdata_i,
  output logic                              rf_we_o,
  output logic [AddrWidth-1:0]              rf_waddr_o,
  output logic [DataWidth-1:0]              rf_wdata_o,
  input  logic                              sb_set_i,
  input  logic [AddrWidth-1:0]              sb_set_addr_i,
  input  logic [NumRead-1:0][AddrWidth-1:0] rs_addr_i,
  input  logic [NumRead-1:0]                rs_use_i,
  output logic                              hazard_o,
  output logic [NumWords-1:0]               busy_o
);

  wb_src_e              r_ptr;
  logic                 r_we;
  logic [AddrWidth-1:0] r_waddr;
  logic [DataWidth-1:0] r_wdata;

  logic    w_fpu_gnt;
  logic    w_mem_gnt;
  logic    w_contend;
  wb_req_t w_win;

  // The output register always drains, so grants never look downstream.
  assign w_contend = fpu_valid_i & mem_valid_i;
  assign w_fpu_gnt = fpu_valid_i & (~mem_valid_i | (r_ptr == WB_FPU));
  assign w_mem_gnt = mem_valid_i & (~fpu_valid_i | (r_ptr == WB_MEM));

  assign fpu_ready_o = w_fpu_gnt;
  assign mem_ready_o = w_mem_gnt;

  always_comb begin
    w_win.addr = fpu_waddr_i;
    w_win.data = fpu_wdata_i;
    if (w_mem_gnt) begin
      w_win.addr = mem_waddr_i;
      w_win.data = mem_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= WB_FPU;
    end else if (w_contend) begin
      r_ptr <= (r_ptr == WB_FPU) ? WB_MEM : WB_FPU;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_fpu_gnt | w_mem_gnt;
      if (w_fpu_gnt | w_mem_gnt) begin
        r_waddr <= w_win.addr;
        r_wdata <= w_win.data;
      end
    end
  end

  assign rf_we_o    = r_we;
  assign rf_waddr_o = r_waddr;
  assign rf_wdata_o = r_wdata;

  // Clear follows the registered write so busy drops on the regfile store edge.
  fpu_ss_scoreboard #(
    .NumWords  (NumWords),
    .AddrWidth (AddrWidth),
    .NumRead   (NumRead)
  ) u_sb (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_set      (sb_set_i),
    .i_set_addr (sb_set_addr_i),
    .i_clr      (r_we),
    .i_clr_addr (r_waddr),
    .i_rs_addr  (rs_addr_i),
    .i_rs_use   (rs_use_i),
    .o_hazard   (hazard_o),
    .o_busy     (busy_o)
  );

endmodule

// File: tb/tb_fpu_ss_wb_ctrl.sv
// Directed bench for fpu_ss_wb_ctrl: arbitration, output latency, scoreboard.
module tb_fpu_ss_wb_ctrl;

  logic            clk;
  logic            rst_n;
  logic            fpu_valid, mem_valid;
  logic            fpu_ready, mem_ready;
  logic [4:0]      fpu_waddr, mem_waddr;
  logic [31:0]     fpu_wdata, mem_wdata;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic            sb_set;
  logic [4:0]      sb_set_addr;
  logic [2:0][4:0] rs_addr;
  logic [2:0]      rs_use;
  logic            hazard;
  logic [31:0]     busy;

  int checks = 0;
  int fails  = 0;

  fpu_ss_wb_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fpu_valid_i   (fpu_valid),
    .fpu_ready_o   (fpu_ready),
    .fpu_waddr_i   (fpu_waddr),
    .fpu_wdata_i   (fpu_wdata),
    .mem_valid_i   (mem_valid),
    .mem_ready_o   (mem_ready),
    .mem_waddr_i   (mem_waddr),
    .mem_wdata_i   (mem_wdata),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .sb_set_i      (sb_set),
    .sb_set_addr_i (sb_set_addr),
    .rs_addr_i     (rs_addr),
    .rs_use_i      (rs_use),
    .hazard_o      (hazard),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue protocol: never mark a destination while issue is told to stall.
  always @(posedge clk) begin
    if (rst_n && sb_set && hazard) begin
      fails++;
      $error("FAIL sb_set_under_hazard: observed 1 expected 0");
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  exp_waddr [4];
  logic        exp_fgnt  [4];
  logic [4:0]  fq, mq;

  initial begin
    rst_n = 1'b0; fpu_valid = 0; mem_valid = 0;
    fpu_waddr = 0; fpu_wdata = 0; mem_waddr = 0; mem_wdata = 0;
    sb_set = 0; sb_set_addr = 0; rs_addr = '0; rs_use = '0;
    tick; tick;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hazard", hazard, 0);
    rst_n = 1'b1;
    tick;

    // FPU alone: same-cycle ready, write one cycle later, then idle.
    fpu_valid = 1; fpu_waddr = 5'd3; fpu_wdata = 32'h3F80_0000; #1;
    chk("solo_fpu_ready", fpu_ready, 1);
    chk("solo_mem_ready", mem_ready, 0);
    tick;
    fpu_valid = 0;
    chk("solo_we", rf_we, 1);
    chk("solo_waddr", rf_waddr, 3);
    chk("solo_wdata", rf_wdata, 32'h3F80_0000);
    tick;
    chk("solo_we_drop", rf_we, 0);
    chk("solo_waddr_hold", rf_waddr, 3);
    chk("solo_wdata_hold", rf_wdata, 32'h3F80_0000);

    // Contention: alternating grants, loser holds its request.
    exp_fgnt[0] = 1; exp_fgnt[1] = 0; exp_fgnt[2] = 1; exp_fgnt[3] = 0;
    exp_waddr[0] = 5'd1; exp_waddr[1] = 5'd9; exp_waddr[2] = 5'd2; exp_waddr[3] = 5'd10;
    fq = 5'd1; mq = 5'd9;
    for (int c = 0; c < 4; c++) begin
      fpu_valid = 1; fpu_waddr = fq; fpu_wdata = 32'hF000_0000 | 32'(fq);
      mem_valid = 1; mem_waddr = mq; mem_wdata = 32'hA000_0000 | 32'(mq);
      #1;
      chk("cont_fpu_ready", fpu_ready, exp_fgnt[c]);
      chk("cont_mem_ready", mem_ready, !exp_fgnt[c]);
      tick;
      chk("cont_we", rf_we, 1);
      chk("cont_waddr", rf_waddr, exp_waddr[c]);
      chk("cont_wdata", rf_wdata, (exp_fgnt[c] ? 32'hF000_0000 : 32'hA000_0000) | 32'(exp_waddr[c]));
      if (exp_fgnt[c]) fq = fq + 5'd1; else mq = mq + 5'd1;
    end
    fpu_valid = 0; mem_valid = 0;
    tick;
    chk("cont_idle_we", rf_we, 0);

    // RAW on f5 through operand 1.
    sb_set = 1; sb_set_addr = 5'd5; #1;
    chk("raw_set_nohaz", hazard, 0);
    tick;
    sb_set = 0;
    chk("raw_busy5", busy, 32'h0000_0020);
    rs_addr[1] = 5'd5; rs_use = 3'b000; #1;
    chk("raw_unused", hazard, 0);
    rs_use = 3'b010; #1;
    chk("raw_used", hazard, 1);
    tick;
    chk("raw_hold", hazard, 1);
    fpu_valid = 1; fpu_waddr = 5'd5; fpu_wdata = 32'h4000_0000; #1;
    chk("raw_wb_ready", fpu_ready, 1);
    chk("raw_wb_haz", hazard, 1);
    tick;
    fpu_valid = 0;
    chk("raw_we5", rf_we, 1);
    chk("raw_waddr5", rf_waddr, 5);
    chk("raw_nofwd", hazard, 1);
    tick;
    chk("raw_clear", hazard, 0);
    chk("raw_busy0", busy, 0);
    rs_use = 3'b000;

    // Set and clear of f7 on the same edge: set wins.
    fpu_valid = 1; fpu_waddr = 5'd7; fpu_wdata = 32'h1234_5678; #1;
    tick;
    fpu_valid = 0;
    chk("coll_we7", rf_we, 1);
    chk("coll_waddr7", rf_waddr, 7);
    sb_set = 1; sb_set_addr = 5'd7; #1;
    chk("coll_nohaz", hazard, 0);
    tick;
    sb_set = 0;
    chk("coll_busy7", busy, 32'h0000_0080);

    // WAW on f8, plus multi-operand RAW patterns.
    sb_set = 1; sb_set_addr = 5'd8; #1;
    tick;
    sb_set = 0;
    chk("waw_busy", busy, 32'h0000_0180);
    sb_set = 1; sb_set_addr = 5'd8; #1;
    chk("waw_hazard", hazard, 1);
    sb_set = 0; #1;
    chk("waw_drop", hazard, 0);
    rs_addr[0] = 5'd1; rs_addr[1] = 5'd2; rs_addr[2] = 5'd8;
    rs_use = 3'b011; #1;
    chk("raw_multi_clean", hazard, 0);
    rs_use = 3'b100; #1;
    chk("raw_multi_op2", hazard, 1);
    rs_use = 3'b000;
    tick;

    // Build busy=0x120 with a write pending and the pointer on MEM.
    fpu_valid = 1; fpu_waddr = 5'd7; fpu_wdata = 32'h0; #1;
    tick;
    fpu_valid = 0;
    tick;
    chk("pre_busy8", busy, 32'h0000_0100);
    sb_set = 1; sb_set_addr = 5'd5;
    fpu_valid = 1; fpu_waddr = 5'd12; fpu_wdata = 32'hCAFE_0000;
    mem_valid = 1; mem_waddr = 5'd13; mem_wdata = 32'hBEEF_0000; #1;
    chk("pre_fpu_win", fpu_ready, 1);
    tick;
    sb_set = 0; fpu_valid = 0; mem_valid = 0;
    chk("pre_busy", busy, 32'h0000_0120);
    chk("pre_we", rf_we, 1);
    chk("pre_waddr", rf_waddr, 12);
    #3;
    rst_n = 1'b0; #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_we", rf_we, 0);
    chk("mrst_waddr", rf_waddr, 0);
    chk("mrst_wdata", rf_wdata, 0);
    tick;
    rst_n = 1'b1;
    tick;
    fpu_valid = 1; fpu_waddr = 5'd20; fpu_wdata = 32'h2020_2020;
    mem_valid = 1; mem_waddr = 5'd21; mem_wdata = 32'h2121_2121; #1;
    chk("post_fpu_first", fpu_ready, 1);
    chk("post_mem_wait", mem_ready, 0);
    tick;
    fpu_valid = 0; mem_valid = 0;
    chk("post_waddr", rf_waddr, 20);
    tick;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
